// File: rtl/sram_page_manager_pkg.sv
// Shared types and default configuration for the SRAM page manager slice.
// Typedefs are sized for the default configuration (2048 pages, 16 ports).
package sram_page_manager_pkg;

  localparam int unsigned NUM_PORTS_DEF = 16;
  localparam int unsigned PORT_W_DEF    = $clog2(NUM_PORTS_DEF);
  localparam int unsigned DEPTH_DEF     = 2048;
  localparam int unsigned ADDR_W_DEF    = $clog2(DEPTH_DEF);
  localparam int unsigned ECC_W_DEF     = 8;
  localparam int unsigned FREE_WM_DEF   = 64;
  localparam int unsigned PORT_WM_DEF   = 512;

  typedef logic [ADDR_W_DEF-1:0] page_addr_t;
  typedef logic [PORT_W_DEF-1:0] port_id_t;
  typedef logic [ADDR_W_DEF:0]   cnt_t;

  typedef enum logic {
    INIT,
    RUN
  } pm_state_e;

endpackage

// File: rtl/sram_page_manager_if.sv
// Bus bundle between the write-path allocator / read-path releaser and the
// page manager.
//  ECC side-store : ecc_wr_en/ecc_wr_addr/ecc_din, ecc_rd_en/ecc_rd_addr -> ecc_dout
//  Allocate       : wr_op/wr_port takes null_ptr
//  Release        : rd_op/rd_port/rd_addr returns a page
//  Status         : free_space, port_amount, init_done, low_space, port_hi,
//                   err_ovf, err_udf
// slave = page manager side, master = client side.
interface sram_page_manager_if #(
  parameter int unsigned NUM_PORTS = sram_page_manager_pkg::NUM_PORTS_DEF,
  parameter int unsigned PORT_W    = sram_page_manager_pkg::PORT_W_DEF,
  parameter int unsigned ADDR_W    = sram_page_manager_pkg::ADDR_W_DEF,
  parameter int unsigned ECC_W     = sram_page_manager_pkg::ECC_W_DEF
);

  logic                             ecc_wr_en;
  logic [ADDR_W-1:0]                ecc_wr_addr;
  logic [ECC_W-1:0]                 ecc_din;
  logic                             ecc_rd_en;
  logic [ADDR_W-1:0]                ecc_rd_addr;
  logic [ECC_W-1:0]                 ecc_dout;

  logic                             wr_op;
  logic [PORT_W-1:0]                wr_port;
  logic                             rd_op;
  logic [PORT_W-1:0]                rd_port;
  logic [ADDR_W-1:0]                rd_addr;

  logic [ADDR_W-1:0]                null_ptr;
  logic [ADDR_W:0]                  free_space;
  logic [NUM_PORTS-1:0][ADDR_W:0]   port_amount;
  logic                             init_done;
  logic                             low_space;
  logic [NUM_PORTS-1:0]             port_hi;
  logic                             err_ovf;
  logic                             err_udf;

  modport slave (
    input  ecc_wr_en, ecc_wr_addr, ecc_din, ecc_rd_en, ecc_rd_addr,
    input  wr_op, wr_port, rd_op, rd_port, rd_addr,
    output ecc_dout, null_ptr, free_space, port_amount, init_done,
    output low_space, port_hi, err_ovf, err_udf
  );

  modport master (
    output ecc_wr_en, ecc_wr_addr, ecc_din, ecc_rd_en, ecc_rd_addr,
    output wr_op, wr_port, rd_op, rd_port, rd_addr,
    input  ecc_dout, null_ptr, free_space, port_amount, init_done,
    input  low_space, port_hi, err_ovf, err_udf
  );

endinterface

// File: rtl/sram_page_manager_page_free_list.sv
// Circular free-page list: a DEPTH-entry RAM of page addresses with head
// (next page to hand out) and tail (slot for the next returned page).
//  clk, rst_n : clock, async active-low reset
//  init_en    : fill phase, writes list[init_cnt] = init_cnt each cycle
//  init_last  : high on the final fill cycle
//  pop        : advance head (page at head_addr consumed)
//  push       : write push_addr at tail, advance tail
//  head_addr  : combinational list[head]
module page_free_list #(
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_en,
  input  logic              pop,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] head_addr,
  output logic              init_last
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] list_mem [DEPTH];
  logic [ADDR_W-1:0] head_q;
  logic [ADDR_W-1:0] tail_q;
  logic [ADDR_W-1:0] init_cnt_q;

  assign head_addr = list_mem[head_q];
  assign init_last = init_en && (init_cnt_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (init_en) begin
      list_mem[init_cnt_q] <= init_cnt_q;
    end else if (push) begin
      list_mem[tail_q] <= push_addr;
    end
  end

  // The fill uses init_cnt, so tail stays at 0 through INIT, which is
  // exactly where a tail advanced DEPTH times would have wrapped to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      init_cnt_q <= '0;
    end else if (init_en) begin
      init_cnt_q <= init_cnt_q + PTR_ONE;
    end else begin
      if (pop) begin
        head_q <= head_q + PTR_ONE;
      end
      if (push) begin
        tail_q <= tail_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/sram_page_manager.sv
// Page-state keeper for one shared packet SRAM: per-page ECC side-store,
// free-page list, free-space and per-port occupancy counters, watermark
// and error flags. Fills its free list for DEPTH cycles after reset.
//  clk, rst_n : clock, async active-low reset
//  bus        : slave side of sram_page_manager_if (ECC access, alloc/release
//               ops, status outputs)
module sram_page_manager
  import sram_page_manager_pkg::*;
#(
  parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
  parameter int unsigned PORT_W    = $clog2(NUM_PORTS),
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned ECC_W     = ECC_W_DEF,
  parameter int unsigned FREE_WM   = FREE_WM_DEF,
  parameter int unsigned PORT_WM   = PORT_WM_DEF
) (
  input logic                clk,
  input logic                rst_n,
  sram_page_manager_if.slave bus
);

  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] FREE_WM_C = (ADDR_W+1)'(FREE_WM);
  localparam logic [ADDR_W:0] PORT_WM_C = (ADDR_W+1)'(PORT_WM);

  pm_state_e state_q, state_d;

  logic                           init_en;
  logic                           init_last;
  logic                           wr_ok;
  logic                           rd_ok;
  logic                           ovf_d;
  logic                           udf_d;
  logic                           err_ovf_q;
  logic                           err_udf_q;
  logic [ADDR_W-1:0]              head_addr;
  logic [ADDR_W:0]                free_q, free_d;
  logic [NUM_PORTS-1:0][ADDR_W:0] amt_q, amt_d;
  logic [NUM_PORTS-1:0]           wr_hit;
  logic [NUM_PORTS-1:0]           rd_hit;
  logic [NUM_PORTS-1:0]           port_hi_v;
  logic [ECC_W-1:0]               ecc_mem [DEPTH];
  logic [ECC_W-1:0]               ecc_dout_q;

  page_free_list #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_free_list (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_en   (init_en),
    .pop       (wr_ok),
    .push      (rd_ok),
    .push_addr (bus.rd_addr),
    .head_addr (head_addr),
    .init_last (init_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // A wr_op at zero free space is rejected even if a release lands in the
  // same cycle; the released page only becomes allocatable next cycle.
  always_comb begin
    state_d = state_q;
    init_en = 1'b0;
    wr_ok   = 1'b0;
    rd_ok   = 1'b0;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    case (state_q)
      INIT: begin
        init_en = 1'b1;
        ovf_d   = bus.wr_op;
        udf_d   = bus.rd_op;
        if (init_last) begin
          state_d = RUN;
        end
      end
      RUN: begin
        wr_ok = bus.wr_op && (free_q != '0);
        rd_ok = bus.rd_op && (amt_q[bus.rd_port] != '0);
        ovf_d = bus.wr_op && !wr_ok;
        udf_d = bus.rd_op && !rd_ok;
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      wr_hit[p] = wr_ok && (bus.wr_port == PORT_W'(p));
      rd_hit[p] = rd_ok && (bus.rd_port == PORT_W'(p));
    end
  end

  always_comb begin
    free_d = free_q;
    if (init_en) begin
      free_d = free_q + CNT_ONE;
    end else if (wr_ok && !rd_ok) begin
      free_d = free_q - CNT_ONE;
    end else if (rd_ok && !wr_ok) begin
      free_d = free_q + CNT_ONE;
    end
    amt_d = amt_q;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (wr_hit[p] && !rd_hit[p]) begin
        amt_d[p] = amt_q[p] + CNT_ONE;
      end else if (rd_hit[p] && !wr_hit[p]) begin
        amt_d[p] = amt_q[p] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_q    <= '0;
      amt_q     <= '0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      free_q    <= free_d;
      amt_q     <= amt_d;
      err_ovf_q <= ovf_d;
      err_udf_q <= udf_d;
    end
  end

  // ECC side-store: the NBA write makes a same-cycle read return old data.
  always_ff @(posedge clk) begin
    if (bus.ecc_wr_en) begin
      ecc_mem[bus.ecc_wr_addr] <= bus.ecc_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecc_dout_q <= '0;
    end else if (bus.ecc_rd_en) begin
      ecc_dout_q <= ecc_mem[bus.ecc_rd_addr];
    end
  end

  always_comb begin
    port_hi_v = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      port_hi_v[p] = amt_q[p] >= PORT_WM_C;
    end
  end

  assign bus.ecc_dout    = ecc_dout_q;
  assign bus.null_ptr    = head_addr;
  assign bus.free_space  = free_q;
  assign bus.port_amount = amt_q;
  assign bus.init_done   = (state_q == RUN);
  assign bus.low_space   = free_q <= FREE_WM_C;
  assign bus.port_hi     = port_hi_v;
  assign bus.err_ovf     = err_ovf_q;
  assign bus.err_udf     = err_udf_q;

endmodule

// File: tb/tb_sram_page_manager.sv
// Bench for sram_page_manager: queue-based free-list model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_sram_page_manager;
  import sram_page_manager_pkg::*;

  localparam int unsigned NP  = 16;
  localparam int unsigned DEP = 2048;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_page_manager_if #(.NUM_PORTS(NP), .PORT_W(4), .ADDR_W(11), .ECC_W(8)) bus ();

  sram_page_manager #(
    .NUM_PORTS (NP),
    .PORT_W    (4),
    .DEPTH     (DEP),
    .ADDR_W    (11),
    .ECC_W     (8),
    .FREE_WM   (64),
    .PORT_WM   (512)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: the free list is a plain FIFO of page numbers.
  int unsigned fq[$];
  int unsigned m_amt[NP];
  bit          m_run;
  int unsigned m_init;
  bit          m_ovf, m_udf;
  logic [7:0]  m_ecc_out;
  bit          m_ecc_ok;
  logic [7:0]  m_ecc_mem [DEP];
  bit          m_ecc_known [DEP];
  bit          wok, rok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      foreach (m_amt[p]) m_amt[p] = 0;
      m_run = 0; m_init = 0; m_ovf = 0; m_udf = 0;
      m_ecc_out = 8'h00; m_ecc_ok = 1;
    end else begin
      if (bus.ecc_rd_en) begin
        m_ecc_ok  = m_ecc_known[bus.ecc_rd_addr];
        m_ecc_out = m_ecc_mem[bus.ecc_rd_addr];
      end
      if (bus.ecc_wr_en) begin
        m_ecc_mem[bus.ecc_wr_addr]   = bus.ecc_din;
        m_ecc_known[bus.ecc_wr_addr] = 1;
      end
      if (!m_run) begin
        m_ovf = bus.wr_op;
        m_udf = bus.rd_op;
        fq.push_back(m_init);
        m_init++;
        m_run = (m_init == DEP);
      end else begin
        wok = bus.wr_op && fq.size() != 0;
        rok = bus.rd_op && m_amt[bus.rd_port] != 0;
        m_ovf = bus.wr_op && !wok;
        m_udf = bus.rd_op && !rok;
        if (wok) begin
          void'(fq.pop_front());
          m_amt[bus.wr_port]++;
        end
        if (rok) begin
          fq.push_back(bus.rd_addr);
          m_amt[bus.rd_port]--;
        end
      end
    end
  end

  int unsigned dsum;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("init_done", bus.init_done, m_run);
      chk("free_space", bus.free_space, fq.size());
      chk("low_space", bus.low_space, fq.size() <= 64);
      chk("err_ovf", bus.err_ovf, m_ovf);
      chk("err_udf", bus.err_udf, m_udf);
      dsum = bus.free_space;
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("amt[%0d]", p), bus.port_amount[p], m_amt[p]);
        chk($sformatf("port_hi[%0d]", p), bus.port_hi[p], m_amt[p] >= 512);
        dsum += bus.port_amount[p];
      end
      if (m_run) chk("invariant", dsum, DEP);
      if (m_run && fq.size() > 0) chk("null_ptr", bus.null_ptr, fq[0]);
      if (m_ecc_ok) chk("ecc_dout", bus.ecc_dout, m_ecc_out);
    end
  end

  page_addr_t got;
  int         cyc;

  initial begin
    bus.ecc_wr_en = 0; bus.ecc_wr_addr = '0; bus.ecc_din = '0;
    bus.ecc_rd_en = 0; bus.ecc_rd_addr = '0;
    bus.wr_op = 0; bus.wr_port = '0; bus.rd_op = 0; bus.rd_port = '0; bus.rd_addr = '0;

    repeat (3) tick();
    chk("rst_free", bus.free_space, 0);
    chk("rst_init_done", bus.init_done, 0);
    chk("rst_ecc_dout", bus.ecc_dout, 0);
    chk("rst_err_ovf", bus.err_ovf, 0);
    chk("rst_amt0", bus.port_amount[0], 0);
    rst_n = 1;

    // Fill phase, with rejected ops and an ECC write injected along the way.
    cyc = 0;
    while (!bus.init_done && cyc < 3000) begin
      tick();
      cyc++;
      if (cyc == 4) begin
        bus.wr_op = 1; bus.wr_port = 4'd2;
        bus.ecc_wr_en = 1; bus.ecc_wr_addr = 11'd20; bus.ecc_din = 8'h3C;
      end
      if (cyc == 5) begin
        chk("init_ovf", bus.err_ovf, 1);
        bus.wr_op = 0; bus.ecc_wr_en = 0;
        bus.rd_op = 1; bus.rd_port = 4'd3;
      end
      if (cyc == 6) begin
        chk("init_udf", bus.err_udf, 1);
        chk("init_ovf_clr", bus.err_ovf, 0);
        bus.rd_op = 0;
      end
    end
    chk("init_cycles", cyc, 2048);
    chk("init_free", bus.free_space, 2048);
    chk("init_null", bus.null_ptr, 0);

    for (int i = 0; i < 3; i++) begin
      got = bus.null_ptr;
      chk($sformatf("alloc%0d", i), got, i);
      bus.wr_op = 1; bus.wr_port = 4'd5;
      tick();
    end
    bus.wr_op = 0;
    chk("amt5_3", bus.port_amount[5], 3);
    chk("free_2045", bus.free_space, 2045);

    bus.rd_op = 1; bus.rd_port = 4'd5; bus.rd_addr = 11'd1;
    bus.wr_op = 1; bus.wr_port = 4'd7;
    tick();
    bus.rd_op = 0; bus.wr_op = 0;
    chk("both_free", bus.free_space, 2045);
    chk("both_amt5", bus.port_amount[5], 2);
    chk("both_amt7", bus.port_amount[7], 1);
    chk("model_tail", fq[fq.size()-1], 1);

    // Drain the list; the returned page 1 is the last one handed out.
    for (int i = 0; i < 2045; i++) begin
      if (i == 2044) chk("last_page", bus.null_ptr, 1);
      bus.wr_op = 1; bus.wr_port = 4'd9;
      tick();
    end
    tick();
    bus.wr_op = 0;
    chk("full_ovf", bus.err_ovf, 1);
    chk("full_free", bus.free_space, 0);
    chk("full_low", bus.low_space, 1);
    chk("full_hi9", bus.port_hi[9], 1);
    chk("full_amt9", bus.port_amount[9], 2045);
    tick();
    chk("ovf_pulse_end", bus.err_ovf, 0);

    bus.rd_op = 1; bus.rd_port = 4'd3; bus.rd_addr = 11'd7;
    tick();
    bus.rd_op = 0;
    chk("udf_pulse", bus.err_udf, 1);
    chk("udf_free", bus.free_space, 0);
    chk("udf_amt3", bus.port_amount[3], 0);
    tick();
    chk("udf_pulse_end", bus.err_udf, 0);

    bus.wr_op = 1; bus.wr_port = 4'd2;
    bus.rd_op = 1; bus.rd_port = 4'd9; bus.rd_addr = 11'd100;
    tick();
    bus.wr_op = 0; bus.rd_op = 0;
    chk("nobypass_ovf", bus.err_ovf, 1);
    chk("nobypass_free", bus.free_space, 1);
    chk("nobypass_amt9", bus.port_amount[9], 2044);
    chk("nobypass_amt2", bus.port_amount[2], 0);
    chk("nobypass_null", bus.null_ptr, 100);

    bus.ecc_wr_en = 1; bus.ecc_wr_addr = 11'd10; bus.ecc_din = 8'h5A;
    tick();
    bus.ecc_din = 8'hA5; bus.ecc_rd_en = 1; bus.ecc_rd_addr = 11'd10;
    tick();
    bus.ecc_wr_en = 0; bus.ecc_rd_en = 0;
    chk("ecc_old", bus.ecc_dout, 8'h5A);
    tick();
    chk("ecc_hold", bus.ecc_dout, 8'h5A);
    bus.ecc_rd_en = 1;
    tick();
    chk("ecc_new", bus.ecc_dout, 8'hA5);
    bus.ecc_rd_addr = 11'd20;
    tick();
    bus.ecc_rd_en = 0;
    chk("ecc_init_wr", bus.ecc_dout, 8'h3C);

    bus.wr_op = 1; bus.wr_port = 4'd1;
    tick();
    bus.wr_op = 0;
    #2 rst_n = 0;
    #1;
    chk("midrst_free", bus.free_space, 0);
    chk("midrst_init_done", bus.init_done, 0);
    chk("midrst_amt9", bus.port_amount[9], 0);
    rst_n = 1;
    repeat (5) tick();
    chk("refill_free", bus.free_space, 5);
    chk("refill_init_done", bus.init_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
